// File: rtl/dram_pkg.sv
// Shared types and helpers for the dual-port DRAM model and its refresh scheduler.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package dram_pkg;

  // Scheduler states: normal access service, or a row refresh that stalls both ports.
  typedef enum logic {
    IDLE    = 1'b0,
    REFRESH = 1'b1
  } refresh_state_e;

  // Widest data word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 1024;

  // Even parity: the returned bit makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dram_refresh_sched.sv
// Refresh scheduler: interval timer, single merged pending request, IDLE/REFRESH FSM, row pointer and event count.
// Latency: pending is taken at the next IDLE edge; busy rises the cycle after and lasts REFRESH_CYCLES cycles.
// Backpressure: busy stalls both memory ports; refresh requests arriving at any time merge into one pending event.
module dram_refresh_sched
  import dram_pkg::*;
#(
  parameter int ADDR_W           = 4,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 4,
  parameter int CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_req,
  output logic              busy,
  output logic [ADDR_W-1:0] refresh_row,
  output logic [CNT_W-1:0]  refresh_count
);

  localparam int TIMER_W = $clog2(REFRESH_INTERVAL);
  localparam int PHASE_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  refresh_state_e      state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [PHASE_W-1:0]  phase, phase_n;
  logic                pending, pending_n;
  logic [ADDR_W-1:0]   row, row_n;
  logic [CNT_W-1:0]    count, count_n;

  // Busy comes straight from the state flop, so the ports see a registered ready.
  assign busy          = (state == REFRESH);
  assign refresh_row   = row;
  assign refresh_count = count;

  // State register; reset aborts any refresh in flight without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      phase   <= '0;
      pending <= 1'b0;
      row     <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      phase   <= phase_n;
      pending <= pending_n;
      row     <= row_n;
      count   <= count_n;
    end
  end

  // Next-state: timer only runs in IDLE; a request seen in the consuming cycle survives as a new pending.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    phase_n   = phase;
    pending_n = pending;
    row_n     = row;
    count_n   = count;
    case (state)
      IDLE: begin
        phase_n = '0;
        if (pending) begin
          state_n   = REFRESH;
          pending_n = 1'b0;
          timer_n   = '0;
        end else if (timer == TIMER_W'(REFRESH_INTERVAL - 1)) begin
          timer_n   = '0;
          pending_n = 1'b1;
        end else begin
          timer_n   = timer + 1'b1;
        end
      end
      REFRESH: begin
        timer_n = '0;
        if (phase == PHASE_W'(REFRESH_CYCLES - 1)) begin
          state_n = IDLE;
          phase_n = '0;
          row_n   = row + 1'b1;
          count_n = count + 1'b1;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (refresh_req) begin
      pending_n = 1'b1;
    end
  end

endmodule

// File: rtl/dram_dp_refresh.sv
// Dual-port DRAM model with a row-refresh scheduler; DRAM_PARITY_EN adds a stored even-parity bit, x_perr and inject_perr.
// Latency: writes commit at the accepting edge; reads return registered data one cycle after acceptance.
// Backpressure: a_ready/b_ready are low for the whole refresh window; requests seen then are dropped, not queued.
module dram_dp_refresh
  import dram_pkg::*;
#(
  parameter int DATA_W           = 16,
  parameter int ADDR_W           = 4,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 4,
  parameter int CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
`ifdef DRAM_PARITY_EN
  input  logic              inject_perr,
  output logic              a_perr,
  output logic              b_perr,
`endif
  input  logic              refresh_req,
  output logic              refresh_busy,
  output logic [ADDR_W-1:0] refresh_row,
  output logic [CNT_W-1:0]  refresh_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              busy;
  logic              a_acc, b_acc;
  logic              a_rd, b_rd;
  logic [DATA_W-1:0] mem [DEPTH];

  assign a_ready      = ~busy;
  assign b_ready      = ~busy;
  assign refresh_busy = busy;

  // Nothing is accepted while reset is asserted, even if ready happens to be high.
  assign a_acc = a_req & a_ready & ~rst;
  assign b_acc = b_req & b_ready & ~rst;
  assign a_rd  = a_acc & ~a_we;
  assign b_rd  = b_acc & ~b_we;

  dram_refresh_sched #(
    .ADDR_W           (ADDR_W),
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .REFRESH_CYCLES   (REFRESH_CYCLES),
    .CNT_W            (CNT_W)
  ) u_sched (
    .clk           (clk),
    .rst           (rst),
    .refresh_req   (refresh_req),
    .busy          (busy),
    .refresh_row   (refresh_row),
    .refresh_count (refresh_count)
  );

  // Array write; port A is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (b_acc && b_we) mem[b_addr] <= b_wdata;
    if (a_acc && a_we) mem[a_addr] <= a_wdata;
  end

  // Port A read register; samples the array before this edge's writes land (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      if (a_rd) a_rdata <= mem[a_addr];
    end
  end

  // Port B read register; same read-before-write behaviour as port A.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      b_rvalid <= b_rd;
      if (b_rd) b_rdata <= mem[b_addr];
    end
  end

`ifdef DRAM_PARITY_EN
  logic par_mem [DEPTH];

  // Parity column write; inject_perr flips the stored bit so a later read reports an error.
  always_ff @(posedge clk) begin
    if (b_acc && b_we) par_mem[b_addr] <= even_parity(PAR_MAX_W'(b_wdata)) ^ inject_perr;
    if (a_acc && a_we) par_mem[a_addr] <= even_parity(PAR_MAX_W'(a_wdata)) ^ inject_perr;
  end

  // Parity check alongside each read; the flag is meaningful only with the matching rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_perr <= 1'b0;
      b_perr <= 1'b0;
    end else begin
      if (a_rd) a_perr <= par_mem[a_addr] ^ even_parity(PAR_MAX_W'(mem[a_addr]));
      if (b_rd) b_perr <= par_mem[b_addr] ^ even_parity(PAR_MAX_W'(mem[b_addr]));
    end
  end
`endif

endmodule

// File: tb/tb_dram_dp_refresh.sv
// Self-checking bench for dram_dp_refresh with default parameters (and DRAM_PARITY_EN when defined).
// Latency: outputs compared at each falling edge against a cycle-level behavioural model.
// Backpressure: the model decides acceptance from its own refresh window, never from the DUT.
module tb_dram_dp_refresh;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int RI = 64;
  localparam int RC = 4;
  localparam int CW = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0, refresh_req = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ready, a_rvalid, b_ready, b_rvalid, refresh_busy;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] refresh_row;
  logic [CW-1:0] refresh_count;
  logic          inject_perr = 1'b0;
`ifdef DRAM_PARITY_EN
  logic          a_perr, b_perr;
`endif

  always #5 clk = ~clk;

  dram_dp_refresh #(
    .DATA_W(DW), .ADDR_W(AW), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef DRAM_PARITY_EN
    .inject_perr(inject_perr), .a_perr(a_perr), .b_perr(b_perr),
`endif
    .refresh_req(refresh_req), .refresh_busy(refresh_busy),
    .refresh_row(refresh_row), .refresh_count(refresh_count)
  );

  int checks = 0;
  int errors = 0;
  bit live = 0;

  // Behavioural model: a refresh "window" counted down in cycles instead of an FSM.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_bad [DEPTH];
  int            m_timer = 0, m_left = 0, m_row = 0, m_count = 0;
  bit            m_pending = 0;
  bit            m_a_rvalid = 0, m_b_rvalid = 0, m_a_perr = 0, m_b_perr = 0;
  logic [DW-1:0] m_a_rdata = '0, m_b_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("a_ready", a_ready, (m_left == 0));
    chk("b_ready", b_ready, (m_left == 0));
    chk("refresh_busy", refresh_busy, (m_left != 0));
    chk("a_rvalid", a_rvalid, m_a_rvalid);
    chk("b_rvalid", b_rvalid, m_b_rvalid);
    chk("a_rdata", a_rdata, m_a_rdata);
    chk("b_rdata", b_rdata, m_b_rdata);
    chk("refresh_row", refresh_row, m_row);
    chk("refresh_count", refresh_count, m_count);
`ifdef DRAM_PARITY_EN
    if (m_a_rvalid) chk("a_perr", a_perr, m_a_perr);
    if (m_b_rvalid) chk("b_perr", b_perr, m_b_perr);
`endif
  endtask

  task automatic model_step();
    bit idle, a_rd, b_rd;
    if (rst) begin
      m_timer = 0; m_left = 0; m_pending = 0; m_row = 0; m_count = 0;
      m_a_rvalid = 0; m_b_rvalid = 0; m_a_rdata = '0; m_b_rdata = '0;
      m_a_perr = 0; m_b_perr = 0;
      return;
    end
    idle = (m_left == 0);
    a_rd = idle && a_req && !a_we;
    b_rd = idle && b_req && !b_we;
    if (a_rd) begin m_a_rdata = m_mem[a_addr]; m_a_perr = m_bad[a_addr]; end
    if (b_rd) begin m_b_rdata = m_mem[b_addr]; m_b_perr = m_bad[b_addr]; end
    m_a_rvalid = a_rd;
    m_b_rvalid = b_rd;
    if (idle && b_req && b_we) begin m_mem[b_addr] = b_wdata; m_bad[b_addr] = inject_perr; end
    if (idle && a_req && a_we) begin m_mem[a_addr] = a_wdata; m_bad[a_addr] = inject_perr; end
    if (idle) begin
      if (m_pending) begin
        m_left = RC; m_pending = 0; m_timer = 0;
      end else if (m_timer == RI - 1) begin
        m_timer = 0; m_pending = 1;
      end else begin
        m_timer++;
      end
    end else begin
      m_left--;
      m_timer = 0;
      if (m_left == 0) begin
        m_row = (m_row + 1) % DEPTH;
        m_count = (m_count + 1) % (1 << CW);
      end
    end
    if (refresh_req) m_pending = 1;
  endtask

  // One clock: compare current outputs, advance the model with the driven inputs, move to next falling edge.
  task automatic cycle();
    if (live) compare_outputs();
    model_step();
    if (rst) live = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; refresh_req = 0; inject_perr = 0;
  endtask

  task automatic wait_busy(input string nm);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (refresh_busy) got = 1;
      else cycle();
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
  endtask

  // Counts cycles after reset release until busy rises, optionally prefilling the array on port A.
  task automatic count_to_busy(input bit prefill, output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (prefill && i < DEPTH) begin
        a_req = 1; a_we = 1; a_addr = AW'(i);
        a_wdata = (i == 6) ? 16'h0042 : (16'h0100 + 16'(i));
      end else begin
        a_req = 0; a_we = 0;
      end
      cycle();
      n++;
      if (refresh_busy) got = 1;
    end
    a_req = 0; a_we = 0;
  endtask

  initial begin
    int n, bl, c0, ph, gap;
    bit done;
    idle_inputs();
    @(negedge clk);
    rst = 1; cycle(); cycle();
    rst = 0;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_busy", refresh_busy, 0);
    chk("rst_count", refresh_count, 0);
    chk("rst_row", refresh_row, 0);
    chk("rst_a_rvalid", a_rvalid, 0);

    // Automatic refresh after an idle interval; array prefilled meanwhile.
    count_to_busy(1, n);
    chk("auto_refresh_start", n, 65);
    a_req = 1; a_we = 1; a_addr = 4'd7; a_wdata = 16'hDEAD;
    b_req = 1; b_we = 0; b_addr = 4'd1;
    bl = 1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("stall_b_rvalid", b_rvalid, 0);
      if (!refresh_busy) break;
      bl++;
    end
    idle_inputs();
    chk("refresh_len", bl, 4);
    chk("row_after_1", refresh_row, 1);
    chk("count_after_1", refresh_count, 1);
    a_req = 1; a_we = 0; a_addr = 4'd7; cycle(); a_req = 0;
    chk("dropped_write_rvalid", a_rvalid, 1);
    chk("dropped_write_data", a_rdata, 16'h0107);

    // Basic write then read on port A.
    a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 16'hBEEF; cycle();
    a_we = 0; cycle(); a_req = 0;
    chk("beef_rvalid", a_rvalid, 1);
    chk("beef_rdata", a_rdata, 16'hBEEF);
    chk("beef_b_rvalid", b_rvalid, 0);

    // Same-address collisions.
    a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = 16'h1111;
    b_req = 1; b_we = 1; b_addr = 4'd5; b_wdata = 16'h2222; cycle();
    a_req = 0; b_we = 0; cycle(); b_req = 0;
    chk("both_write_a_wins", b_rdata, 16'h1111);
    a_req = 1; a_we = 1; a_addr = 4'd6; a_wdata = 16'h3333;
    b_req = 1; b_we = 0; b_addr = 4'd6; cycle();
    a_we = 0; b_req = 0; cycle(); a_req = 0;
    chk("rbw_b_rvalid", b_rvalid, 0);
    chk("rbw_b_old", b_rdata, 16'h0042);
    chk("rbw_a_new", a_rdata, 16'h3333);

    // Two external requests during one refresh merge into one extra refresh.
    refresh_req = 1; cycle(); refresh_req = 0;
    wait_busy("merge");
    c0 = refresh_count;
    refresh_req = 1; cycle(); refresh_req = 0; cycle();
    refresh_req = 1; cycle(); refresh_req = 0;
    ph = 0; gap = 0; done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      cycle();
      if (ph == 0 && !refresh_busy) begin ph = 1; gap = 1; end
      else if (ph == 1) begin if (refresh_busy) ph = 2; else gap++; end
      else if (ph == 2 && !refresh_busy) done = 1;
    end
    chk("merge_done", done, 1);
    chk("merge_gap", gap, 1);
    chk("merge_count", refresh_count, c0 + 2);
    for (int k = 0; k < 10; k++) cycle();
    chk("merge_no_third", refresh_count, c0 + 2);

    // Row pointer wraps after DEPTH refreshes.
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      refresh_req = 1; cycle();
      if (refresh_count == 16) done = 1;
    end
    refresh_req = 0;
    chk("wrap_reached", done, 1);
    chk("wrap_row", refresh_row, 0);
    for (int k = 0; k < 20; k++) cycle();

    // Reset in the second refresh cycle aborts the refresh.
    refresh_req = 1; cycle(); refresh_req = 0;
    wait_busy("abort");
    cycle();
    chk("abort_in_refresh", refresh_busy, 1);
    rst = 1; cycle(); rst = 0;
    chk("abort_ready", a_ready, 1);
    chk("abort_busy", refresh_busy, 0);
    chk("abort_count", refresh_count, 0);
    chk("abort_row", refresh_row, 0);
    count_to_busy(0, n);
    chk("abort_timer_restart", n, 65);
    for (int k = 0; k < 6; k++) cycle();

`ifdef DRAM_PARITY_EN
    a_req = 1; a_we = 1; a_addr = 4'd2; a_wdata = 16'h0001; inject_perr = 1; cycle();
    inject_perr = 0; a_we = 0; cycle(); a_req = 0;
    chk("perr_injected", a_perr, 1);
    a_req = 1; a_we = 1; a_wdata = 16'h0001; cycle();
    a_we = 0; cycle(); a_req = 0;
    chk("perr_clean", a_perr, 0);
`endif

    // Randomized traffic with occasional refresh requests and resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (rst) begin
        idle_inputs();
      end else begin
        a_req = ($urandom_range(0, 3) != 0);
        b_req = ($urandom_range(0, 3) != 0);
        a_we = $urandom_range(0, 1);
        b_we = $urandom_range(0, 1);
        a_addr = AW'($urandom_range(0, DEPTH - 1));
        b_addr = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, DEPTH - 1));
        a_wdata = DW'($urandom);
        b_wdata = DW'($urandom);
        refresh_req = ($urandom_range(0, 19) == 0);
        inject_perr = ($urandom_range(0, 7) == 0);
      end
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
